// File: rtl/fan_pkg.sv
// Shared types and constants for the fan speed controller: speed states,
// duty fractions of the PWM period, and the auto-off timer presets.
package fan_pkg;

  typedef enum logic [1:0] {
    SPD_OFF  = 2'd0,
    SPD_LOW  = 2'd1,
    SPD_MID  = 2'd2,
    SPD_HIGH = 2'd3
  } speed_e;

  localparam int unsigned DUTY_DEN      = 10;
  localparam int unsigned DUTY_NUM_LOW  = 3;
  localparam int unsigned DUTY_NUM_MID  = 6;
  localparam int unsigned DUTY_NUM_HIGH = 9;

  localparam logic [8:0] TIMER_PRESET_1 = 9'd60;
  localparam logic [8:0] TIMER_PRESET_2 = 9'd180;
  localparam logic [8:0] TIMER_PRESET_3 = 9'd300;

  function automatic logic [9:0] duty_target(speed_e s, int unsigned period);
    int unsigned num;
    case (s)
      SPD_LOW:  num = DUTY_NUM_LOW;
      SPD_MID:  num = DUTY_NUM_MID;
      SPD_HIGH: num = DUTY_NUM_HIGH;
      default:  num = 0;
    endcase
    return 10'(period * num / DUTY_DEN);
  endfunction

  // Index 0 is the idle (no timer) slot; the button walks 0->1->2->3->0.
  function automatic logic [8:0] timer_preset(logic [1:0] idx);
    case (idx)
      2'd1:    return TIMER_PRESET_1;
      2'd2:    return TIMER_PRESET_2;
      2'd3:    return TIMER_PRESET_3;
      default: return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/fan_tick_gen.sv
// Single-cycle enable once every CLK_DIV system clocks; no derived clock,
// first pulse lands CLK_DIV cycles after reset release.
module fan_tick_gen
  import fan_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == DIV_LAST);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fan_speed_controller.sv
// Three-speed fan controller: button-driven speed FSM, ramped PWM duty and an
// auto-off countdown timer, all advancing on a 1 us tick enable.
module fan_speed_controller
  import fan_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 100,
  parameter int unsigned PWM_PERIOD    = 1000,
  parameter int unsigned RAMP_STEP     = 10,
  parameter int unsigned TICKS_PER_SEC = 1000000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn_speed,
  input  logic       i_btn_timer,
  input  logic       i_btn_off,
  output logic       o_pwm,
  output logic [1:0] o_speed,
  output logic [9:0] o_duty,
  output logic [8:0] o_timer_sec
);

  localparam int unsigned SEC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [9:0]       PWM_LAST = 10'(PWM_PERIOD - 1);
  localparam logic [9:0]       STEP     = 10'(RAMP_STEP);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TICKS_PER_SEC - 1);

  logic             tick;
  speed_e           state_q, state_d;
  logic [8:0]       timer_q, timer_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [1:0]       preset_idx_q, preset_idx_d;
  logic             expire_q, expire_d;
  logic [9:0]       pwm_cnt_q, pwm_cnt_d;
  logic [9:0]       duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic [9:0]       target;
  logic             wrap;
  logic             enter_off;

  fan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .tick_o (tick)
  );

  // Expiry is a registered flag so OFF is entered the cycle after 1 -> 0.
  assign enter_off = i_btn_off || expire_q || (i_btn_speed && (state_q == SPD_HIGH));
  assign wrap      = tick && (pwm_cnt_q == PWM_LAST);
  assign target    = duty_target(state_q, PWM_PERIOD);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    sec_cnt_d    = sec_cnt_q;
    preset_idx_d = preset_idx_q;
    expire_d     = 1'b0;
    if (enter_off) begin
      state_d      = SPD_OFF;
      timer_d      = '0;
      sec_cnt_d    = '0;
      preset_idx_d = '0;
    end else begin
      if (i_btn_speed) state_d = speed_e'(state_q + 2'd1);
      if (i_btn_timer && (state_q != SPD_OFF)) begin
        preset_idx_d = preset_idx_q + 2'd1;
        timer_d      = timer_preset(preset_idx_q + 2'd1);
        sec_cnt_d    = '0;
      end else if (tick && (timer_q != 9'd0)) begin
        if (sec_cnt_q == SEC_LAST) begin
          sec_cnt_d = '0;
          timer_d   = timer_q - 9'd1;
          expire_d  = (timer_q == 9'd1);
        end else begin
          sec_cnt_d = sec_cnt_q + SEC_W'(1);
        end
      end
    end
  end

  // Duty only moves at the period wrap, by at most RAMP_STEP toward target.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    if (tick) pwm_cnt_d = wrap ? 10'd0 : pwm_cnt_q + 10'd1;
    duty_d = duty_q;
    if (wrap) begin
      if (duty_q < target)
        duty_d = ((target - duty_q) > STEP) ? duty_q + STEP : target;
      else if (duty_q > target)
        duty_d = ((duty_q - target) > STEP) ? duty_q - STEP : target;
    end
    pwm_d = (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= SPD_OFF;
      timer_q      <= '0;
      sec_cnt_q    <= '0;
      preset_idx_q <= '0;
      expire_q     <= 1'b0;
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      pwm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sec_cnt_q    <= sec_cnt_d;
      preset_idx_q <= preset_idx_d;
      expire_q     <= expire_d;
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      pwm_q        <= pwm_d;
    end
  end

  assign o_pwm       = pwm_q;
  assign o_speed     = state_q;
  assign o_duty      = duty_q;
  assign o_timer_sec = timer_q;

endmodule

// File: tb/tb_fan_speed_controller.sv
// Bench for fan_speed_controller: directed scenarios plus random button traffic,
// checked every cycle against a behavioural model of two instances.
module tb_fan_speed_controller;

  localparam int CLK_DIV = 4;
  localparam int PP      = 100;
  localparam int RS      = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_speed = 1'b0;
  logic btn_timer = 1'b0;
  logic btn_off = 1'b0;

  logic       pwm   [2];
  logic [1:0] spd   [2];
  logic [9:0] duty  [2];
  logic [8:0] tmr   [2];

  always #5 clk = ~clk;

  fan_speed_controller #(
    .CLK_DIV(CLK_DIV), .PWM_PERIOD(PP), .RAMP_STEP(RS), .TICKS_PER_SEC(1000)
  ) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_btn_speed(btn_speed), .i_btn_timer(btn_timer),
    .i_btn_off(btn_off), .o_pwm(pwm[0]), .o_speed(spd[0]), .o_duty(duty[0]),
    .o_timer_sec(tmr[0])
  );

  // Short-second copy so a full countdown to expiry fits in a short run.
  fan_speed_controller #(
    .CLK_DIV(CLK_DIV), .PWM_PERIOD(PP), .RAMP_STEP(RS), .TICKS_PER_SEC(10)
  ) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_btn_speed(btn_speed), .i_btn_timer(btn_timer),
    .i_btn_off(btn_off), .o_pwm(pwm[1]), .o_speed(spd[1]), .o_duty(duty[1]),
    .o_timer_sec(tmr[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int tps[2]     = '{1000, 10};
  int frac[4]    = '{0, 3, 6, 9};
  int presets[4] = '{0, 60, 180, 300};

  int m_edge;
  int m_speed[2], m_duty[2], m_cnt[2], m_timer[2], m_sec[2], m_idx[2];
  bit m_exp[2], m_pwm[2];

  function automatic void model_step(int i, bit tick);
    int tgt, diff;
    bit go_off;
    m_pwm[i] = (m_cnt[i] < m_duty[i]);
    tgt = PP * frac[m_speed[i]] / 10;
    if (tick && m_cnt[i] == PP - 1) begin
      diff = tgt - m_duty[i];
      if (diff > 0)      m_duty[i] += (diff < RS) ? diff : RS;
      else if (diff < 0) m_duty[i] -= (-diff < RS) ? -diff : RS;
    end
    if (tick) m_cnt[i] = (m_cnt[i] + 1) % PP;

    go_off = btn_off || m_exp[i] || (btn_speed && m_speed[i] == 3);
    if (go_off) begin
      m_speed[i] = 0; m_timer[i] = 0; m_sec[i] = 0; m_idx[i] = 0; m_exp[i] = 0;
    end else begin
      bit was_off;
      was_off = (m_speed[i] == 0);
      m_exp[i] = 0;
      if (btn_speed) m_speed[i] = m_speed[i] + 1;
      if (btn_timer && !was_off) begin
        m_idx[i]   = (m_idx[i] + 1) % 4;
        m_timer[i] = presets[m_idx[i]];
        m_sec[i]   = 0;
      end else if (tick && m_timer[i] > 0) begin
        m_sec[i]++;
        if (m_sec[i] == tps[i]) begin
          m_sec[i] = 0;
          m_timer[i]--;
          if (m_timer[i] == 0) m_exp[i] = 1;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge = 0;
      for (int i = 0; i < 2; i++) begin
        m_speed[i] = 0; m_duty[i] = 0; m_cnt[i] = 0; m_timer[i] = 0;
        m_sec[i] = 0; m_idx[i] = 0; m_exp[i] = 0; m_pwm[i] = 0;
      end
    end else begin
      m_edge++;
      for (int i = 0; i < 2; i++) model_step(i, (m_edge % CLK_DIV) == 0);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pwm[%0d]", i),   int'(pwm[i]),  int'(m_pwm[i]));
      check($sformatf("speed[%0d]", i), int'(spd[i]),  m_speed[i]);
      check($sformatf("duty[%0d]", i),  int'(duty[i]), m_duty[i]);
      check($sformatf("timer[%0d]", i), int'(tmr[i]),  m_timer[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_to_edge(input int e);
    int guard = 0;
    while (m_edge < e && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    check("edge_sync", m_edge, e);
  endtask

  task automatic press(input bit s, input bit t, input bit o);
    btn_speed = s; btn_timer = t; btn_off = o;
    @(negedge clk);
    btn_speed = 1'b0; btn_timer = 1'b0; btn_off = 1'b0;
  endtask

  task automatic count_pwm(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(pwm[0]);
    end
  endtask

  int hi;

  initial begin
    repeat (3) @(negedge clk);
    check("lit_rst_pwm", int'(pwm[0]), 0);
    check("lit_rst_speed", int'(spd[0]), 0);
    check("lit_rst_duty", int'(duty[0]), 0);
    check("lit_rst_timer", int'(tmr[0]), 0);
    #2 rst_n = 1'b1;

    // OFF -> LOW, ramp 0->10->20->30 then hold
    wait_to_edge(10);   press(1, 0, 0);
    wait_to_edge(410);  check("lit_low_speed", int'(spd[0]), 1);
                        check("lit_duty_10", int'(duty[0]), 10);
    wait_to_edge(810);  check("lit_duty_20", int'(duty[0]), 20);
    wait_to_edge(1210); check("lit_duty_30", int'(duty[0]), 30);
    wait_to_edge(1610); check("lit_duty_hold", int'(duty[0]), 30);
    count_pwm(400, hi); check("lit_pwm_high_cycles", hi, 120);

    // MID, HIGH, OFF ramps
    wait_to_edge(2010); press(1, 0, 0);
    wait_to_edge(3210); check("lit_duty_60", int'(duty[0]), 60);
    press(1, 0, 0);
    wait_to_edge(4410); check("lit_duty_90", int'(duty[0]), 90);
    press(1, 0, 0);
    wait_to_edge(8010); check("lit_off_duty_0", int'(duty[0]), 0);
                        check("lit_off_speed", int'(spd[0]), 0);
    count_pwm(40, hi);  check("lit_off_pwm_quiet", hi, 0);

    // off beats speed in the same cycle at MID
    wait_to_edge(8050); press(1, 0, 0);
    wait_to_edge(8060); press(1, 0, 0);
    wait_to_edge(8070); press(0, 1, 0);
    wait_to_edge(8080); check("lit_timer_60a", int'(tmr[0]), 60);
    press(1, 0, 1);
    wait_to_edge(8090); check("lit_offspd_speed", int'(spd[0]), 0);
                        check("lit_offspd_timer", int'(tmr[0]), 0);

    // countdown at LOW
    wait_to_edge(8100); press(1, 0, 0);
    wait_to_edge(8110); press(0, 1, 0);
    wait_to_edge(8120); check("lit_timer_60_i0", int'(tmr[0]), 60);
                        check("lit_timer_60_i1", int'(tmr[1]), 60);
    wait_to_edge(11000); check("lit_expired_speed_i1", int'(spd[1]), 0);
                         check("lit_expired_timer_i1", int'(tmr[1]), 0);
                         check("lit_running_speed_i0", int'(spd[0]), 1);
    wait_to_edge(12100); check("lit_timer_still_60", int'(tmr[0]), 60);
    wait_to_edge(12130); check("lit_timer_59", int'(tmr[0]), 59);

    // timer press ignored in OFF
    wait_to_edge(12200); press(0, 0, 1);
    wait_to_edge(12210); press(0, 1, 0);
    wait_to_edge(12220); check("lit_off_timer_ignored", int'(tmr[0]), 0);

    // retarget during ramp-down, then reset at duty 50
    wait_to_edge(12300); press(1, 0, 0);
    wait_to_edge(12310); press(1, 0, 0);
    wait_to_edge(12810); check("lit_duty_50", int'(duty[0]), 50);
                         check("lit_mid_speed", int'(spd[0]), 2);
    #2 rst_n = 1'b0;
    #1;
    check("lit_async_pwm", int'(pwm[0]), 0);
    check("lit_async_speed", int'(spd[0]), 0);
    check("lit_async_duty", int'(duty[0]), 0);
    check("lit_async_timer", int'(tmr[0]), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    count_pwm(1000, hi); check("lit_post_reset_pwm_quiet", hi, 0);

    // random traffic
    repeat (20000) begin
      btn_speed = ($urandom_range(0, 599) == 0);
      btn_timer = ($urandom_range(0, 399) == 0);
      btn_off   = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end
    btn_speed = 1'b0; btn_timer = 1'b0; btn_off = 1'b0;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fan_speed_controller.md
FAN_SPEED_CONTROLLER -- requirements
Module: fan_speed_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100, meaning i_clk cycles per 1 us tick (100 MHz -> 1 MHz).
REQ-002 SHALL have parameter PWM_PERIOD, default 1000, meaning PWM period in ticks (1 kHz PWM).
REQ-003 SHALL have parameter RAMP_STEP, default 10, meaning duty change per PWM period, in ticks.
REQ-004 SHALL have parameter TICKS_PER_SEC, default 1000000, meaning ticks per timer second.
REQ-005 SHALL have port i_clk, input, 1 bit: system clock.
REQ-006 SHALL have port i_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port i_btn_speed, input, 1 bit: debounced single-cycle pulse that advances speed.
REQ-008 SHALL have port i_btn_timer, input, 1 bit: debounced single-cycle pulse that advances the timer preset.
REQ-009 SHALL have port i_btn_off, input, 1 bit: debounced single-cycle pulse that forces OFF.
REQ-010 SHALL have port o_pwm, output, 1 bit: fan motor PWM drive.
REQ-011 SHALL have port o_speed, output, 2 bits: current state (0 OFF, 1 LOW, 2 MID, 3 HIGH).
REQ-012 SHALL have port o_duty, output, 10 bits: current ramped duty, in ticks.
REQ-013 SHALL have port o_timer_sec, output, 9 bits: remaining auto-off seconds (0 = timer idle).

Function
REQ-014 SHALL run a speed FSM OFF->LOW->MID->HIGH->OFF, advancing one state per i_btn_speed pulse.
REQ-015 SHALL enter OFF on i_btn_off from any state; i_btn_off SHALL take priority over a same-cycle i_btn_speed.
REQ-016 SHALL set target duty to 0, PWM_PERIOD*3/10, *6/10 and *9/10 for OFF, LOW, MID and HIGH respectively (300/600/900 by default).
REQ-017 SHALL keep a tick counter 0..PWM_PERIOD-1 that advances once per 1 us tick and wraps to 0.
REQ-018 SHALL move o_duty toward the target by min(RAMP_STEP, |target-duty|) at each wrap to 0, and SHALL NOT change o_duty at any other time.
REQ-019 SHALL drive o_pwm high iff the tick counter < o_duty, registered, so o_pwm is 0 when o_duty = 0.
REQ-020 SHALL cycle i_btn_timer through 0->60->180->300->0 seconds, loading o_timer_sec with the next preset; the pulse SHALL be ignored while in OFF.
REQ-021 SHALL decrement o_timer_sec by 1 every TICKS_PER_SEC ticks while it is nonzero; the second counter SHALL restart from 0 on every preset load.
REQ-022 SHALL enter OFF in the cycle after o_timer_sec decrements from 1 to 0, and expiry SHALL override a same-cycle i_btn_speed.
REQ-023 SHALL clear o_timer_sec and the second counter to 0 on any entry to OFF.
REQ-024 SHALL keep ramping o_duty down to 0 after entering OFF; a speed press during the ramp SHALL retarget without resetting o_duty.

Reset
REQ-025 SHALL, while i_reset_n = 0, immediately drive o_pwm = 0, o_speed = 0 (OFF), o_duty = 0 and o_timer_sec = 0, and clear all counters.
REQ-026 SHALL treat reset asserted mid-ramp or mid-countdown as a full return to the REQ-025 state, with no ramp-down.
REQ-027 SHALL wait until the first 1 us tick after reset release before counting.

Structure
REQ-028 SHALL place in package fan_pkg: the speed-state enum, the duty fractions (3/10, 6/10, 9/10) and the timer presets (60/180/300).
REQ-029 SHALL implement the 1 us tick as sub-module fan_tick_gen, which produces a single-cycle enable every CLK_DIV cycles with no derived clock; all logic SHALL be in the i_clk domain.

Verification
REQ-030 SHALL run the bench with CLK_DIV=4, PWM_PERIOD=100, RAMP_STEP=10 and TICKS_PER_SEC=1000.
REQ-031 SHALL check: speed pulse from OFF -> o_speed=1, o_duty 0->10->20->30 on successive wraps and then holds at 30; o_pwm high for 30 of every 100 ticks.
REQ-032 SHALL check: three further speed pulses -> MID, HIGH, OFF; o_duty ramps toward 60, then 90, then down to 0 in steps of 10, and o_pwm stays 0 once o_duty = 0.
REQ-033 SHALL check: i_btn_off and i_btn_speed in the same cycle at MID -> o_speed=0 and o_timer_sec=0.
REQ-034 SHALL check: at LOW, one timer pulse -> o_timer_sec=60, decrementing every 1000 ticks; at 0 -> o_speed=0. A timer pulse in OFF -> o_timer_sec stays 0.
REQ-035 SHALL check: i_reset_n low mid-ramp at o_duty=50 -> all outputs 0 immediately; after release, no o_pwm activity until a speed pulse.
